// File: rtl/wr_data_control.sv
// AXI write-data beat controller: turns the decompressed stream into WDATA beats
// with WLAST per burst and on the final beat, then waits for every burst response.
module wr_data_control #(
   parameter int DATA_WIDTH  = 512,
   parameter int BURST_BEATS = 64,
   parameter int LEN_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [LEN_WIDTH-1:0]    decompression_length,
   input  logic [DATA_WIDTH-1:0]   din_data,
   input  logic                    din_valid,
   output logic                    din_ready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   output logic                    m_wlast,
   input  logic                    m_bvalid,
   input  logic [1:0]              m_bresp,
   output logic                    m_bready,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int OFF_W    = $clog2(STRB_W);
   localparam int BURST_W  = $clog2(BURST_BEATS);
   // One extra bit so a full-scale length cannot overflow the beat count.
   localparam int BEAT_W   = LEN_WIDTH - OFF_W + 1;
   localparam int BURSTS_W = BEAT_W - BURST_W + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]          state;
   logic [BEAT_W-1:0]   total_beats;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [BEAT_W-1:0]   last_beat;
   logic [BEAT_W-1:0]   start_beats;
   logic [BURSTS_W-1:0] total_bursts;
   logic [BURSTS_W-1:0] start_bursts;
   logic [BURSTS_W-1:0] resp_cnt;
   logic [BURSTS_W-1:0] resp_cnt_next;
   logic [OFF_W-1:0]    tail;
   logic [BURST_W-1:0]  burst_cnt;
   logic                in_data;
   logic                final_beat;
   logic                beat_xfer;
   logic                resp_xfer;

   assign start_beats  = BEAT_W'(decompression_length[LEN_WIDTH-1:OFF_W])
                       + BEAT_W'(decompression_length[OFF_W-1:0] != '0);
   assign start_bursts = BURSTS_W'(start_beats[BEAT_W-1:BURST_W])
                       + BURSTS_W'(start_beats[BURST_W-1:0] != '0);

   assign last_beat  = total_beats - BEAT_W'(1);
   assign final_beat = (beat_cnt == last_beat);
   assign in_data    = (state == S_DATA);
   assign beat_xfer  = in_data & din_valid & m_wready;

   assign m_bready  = (state == S_DATA) | (state == S_RESP);
   // Never count past the expected number of responses.
   assign resp_xfer = m_bvalid & m_bready & (resp_cnt != total_bursts);
   assign resp_cnt_next = resp_cnt + BURSTS_W'(resp_xfer);

   assign din_ready = in_data & m_wready;
   assign m_wvalid  = in_data & din_valid;
   assign m_wdata   = in_data ? din_data : '0;
   assign m_wlast   = m_wvalid & ((burst_cnt == BURST_W'(BURST_BEATS - 1)) | final_beat);
   assign busy      = (state == S_DATA) | (state == S_RESP);
   assign done      = (state == S_DONE);

   always_comb begin
      m_wstrb = '1;
      if (in_data && final_beat && (tail != '0)) begin
         for (int i = 0; i < STRB_W; i++) begin
            m_wstrb[i] = (OFF_W'(i) < tail);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         total_beats  <= '0;
         total_bursts <= '0;
         tail         <= '0;
         beat_cnt     <= '0;
         burst_cnt    <= '0;
         resp_cnt     <= '0;
         error        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  total_beats  <= start_beats;
                  total_bursts <= start_bursts;
                  tail         <= decompression_length[OFF_W-1:0];
                  beat_cnt     <= '0;
                  burst_cnt    <= '0;
                  resp_cnt     <= '0;
                  error        <= 1'b0;
                  state        <= (start_beats == '0) ? S_DONE : S_DATA;
               end
            end
            S_DATA: begin
               if (beat_xfer) begin
                  beat_cnt  <= beat_cnt + BEAT_W'(1);
                  burst_cnt <= burst_cnt + BURST_W'(1);
                  if (final_beat) state <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_cnt_next == total_bursts) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
         // Responses are tracked independently of the data phase.
         if (resp_xfer) begin
            resp_cnt <= resp_cnt_next;
            if (m_bresp != 2'b00) error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wr_data_control.sv
// Directed bench for wr_data_control: beat framing, strobes, response counting,
// error flag and reset behaviour.
module tb_wr_data_control;

   logic          clk;
   logic          rst;
   logic          start;
   logic [31:0]   len;
   logic [511:0]  din_data;
   logic          din_valid;
   logic          din_ready;
   logic [511:0]  m_wdata;
   logic [63:0]   m_wstrb;
   logic          m_wvalid;
   logic          m_wready;
   logic          m_wlast;
   logic          m_bvalid;
   logic [1:0]    m_bresp;
   logic          m_bready;
   logic          busy;
   logic          done;
   logic          error;

   int total = 0;
   int bad   = 0;
   int job   = 0;
   logic [511:0] exp_q[$];
   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   wr_data_control dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .decompression_length (len),
      .din_data             (din_data),
      .din_valid            (din_valid),
      .din_ready            (din_ready),
      .m_wdata              (m_wdata),
      .m_wstrb              (m_wstrb),
      .m_wvalid             (m_wvalid),
      .m_wready             (m_wready),
      .m_wlast              (m_wlast),
      .m_bvalid             (m_bvalid),
      .m_bresp              (m_bresp),
      .m_bready             (m_bready),
      .busy                 (busy),
      .done                 (done),
      .error                (error)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] pat(input int j, input int i);
      logic [31:0] w;
      w = (32'(j) << 24) ^ 32'(i) ^ 32'h5A5A_0000;
      return {16{w}};
   endfunction

   task automatic start_job(input logic [31:0] l);
      @(negedge clk);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
      len   = $urandom;
      job++;
      #1;
   endtask

   // Drives n beats; expects WLAST every 64th beat and on the last, last_strb on the last.
   task automatic send_beats(input int n, input logic [63:0] last_strb, input bit stall);
      int  i;
      int  guard;
      bit  hold;
      bit  exp_last;
      logic [511:0] exp_d;
      i = 0;
      guard = 0;
      hold = 1'b0;
      for (int k = 0; k < n; k++) exp_q.push_back(pat(job, k));
      while (i < n && guard < 4000) begin
         @(negedge clk);
         if (!hold) begin
            din_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            din_data  = pat(job, i);
         end
         m_wready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         exp_last = ((i % 64) == 63) || (i == n - 1);
         chk("wvalid", m_wvalid, din_valid);
         chk("din_ready", din_ready, m_wready);
         chk("wlast", m_wlast, din_valid && exp_last);
         if (din_valid && m_wready) begin
            exp_d = exp_q.pop_front();
            chk("wdata", m_wdata, exp_d);
            chk("wstrb", m_wstrb, (i == n - 1) ? last_strb : ALL_ONES);
            i++;
            hold = 1'b0;
         end else begin
            hold = din_valid;
         end
         guard++;
      end
      if (i < n) chk("beat_timeout", i, n);
      @(negedge clk);
      din_valid = 1'b1;
      m_wready  = 1'b1;
      #1;
      chk("resp_wvalid", m_wvalid, 1'b0);
      chk("resp_din_ready", din_ready, 1'b0);
      chk("resp_bready", m_bready, 1'b1);
      chk("resp_busy", busy, 1'b1);
      din_valid = 1'b0;
      m_wready  = 1'b0;
   endtask

   task automatic send_resp(input logic [1:0] r);
      @(negedge clk);
      m_bvalid = 1'b1;
      m_bresp  = r;
      #1;
      chk("bready", m_bready, 1'b1);
      @(negedge clk);
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; din_data = '0; din_valid = 1'b0;
      m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_din_ready", din_ready, 1'b0);
      chk("rst_wvalid", m_wvalid, 1'b0);
      chk("rst_wlast", m_wlast, 1'b0);
      chk("rst_wstrb", m_wstrb, ALL_ONES);
      chk("rst_bready", m_bready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      rst = 1'b0;

      // 4096 bytes: one full burst
      start_job(32'd4096);
      chk("t1_busy", busy, 1'b1);
      send_beats(64, ALL_ONES, 1'b0);
      send_resp(2'b00);
      chk("t1_done", done, 1'b1);
      chk("t1_busy_done", busy, 1'b0);
      chk("t1_error", error, 1'b0);
      @(negedge clk); #1;
      chk("t1_done_once", done, 1'b0);

      // 8200 bytes: 129 beats, three bursts, 8-byte tail
      start_job(32'd8200);
      send_beats(129, 64'hFF, 1'b0);
      send_resp(2'b00);
      send_resp(2'b00);
      chk("t2_no_done_2", done, 1'b0);
      chk("t2_busy_2", busy, 1'b1);
      send_resp(2'b00);
      chk("t2_done", done, 1'b1);
      @(negedge clk); #1;
      chk("t2_done_once", done, 1'b0);

      // 100 bytes with random stalls: 2 beats, 36-byte tail
      start_job(32'd100);
      send_beats(2, 64'hF_FFFF_FFFF, 1'b1);
      send_resp(2'b00);
      chk("t3_done", done, 1'b1);
      chk("t3_queue_empty", exp_q.size(), 0);

      // zero length
      start_job(32'd0);
      chk("t4_done", done, 1'b1);
      chk("t4_busy", busy, 1'b0);
      @(negedge clk); #1;
      chk("t4_done_once", done, 1'b0);

      // 4097 bytes with SLVERR on the second response
      start_job(32'd4097);
      send_beats(65, 64'h1, 1'b0);
      send_resp(2'b00);
      chk("t5_error_ok", error, 1'b0);
      send_resp(2'b10);
      chk("t5_error_set", error, 1'b1);
      chk("t5_done", done, 1'b1);
      @(negedge clk); #1;
      chk("t5_error_hold", error, 1'b1);
      start_job(32'd0);
      chk("t5_error_clear", error, 1'b0);
      chk("t5_done_zero", done, 1'b1);

      // reset in the middle of a data phase
      start_job(32'd4096);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         din_valid = 1'b1;
         m_wready  = 1'b1;
         din_data  = pat(job, k);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("mid_din_ready", din_ready, 1'b0);
      chk("mid_wvalid", m_wvalid, 1'b0);
      chk("mid_wlast", m_wlast, 1'b0);
      chk("mid_wstrb", m_wstrb, ALL_ONES);
      chk("mid_bready", m_bready, 1'b0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_done", done, 1'b0);
      rst = 1'b0;
      din_valid = 1'b0;
      m_wready  = 1'b0;
      @(negedge clk); #1;
      chk("mid_no_stale_done", done, 1'b0);
      start_job(32'd64);
      chk("t6_no_early_done", done, 1'b0);
      send_beats(1, ALL_ONES, 1'b0);
      send_resp(2'b00);
      chk("t6_done", done, 1'b1);
      chk("t6_error", error, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
